// File: rtl/clkgen_ctrl.sv
// Programmable waveform generator: phase delay, then repeated ton/toff periods,
// with double-buffered configuration that is applied only on period boundaries.
module clkgen_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_ton,
  input  logic [CNT_W-1:0] cfg_toff,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             wave_out,
  output logic             busy,
  output logic             period_done,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_HIGH, S_LOW} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  act_phase_q, act_phase_d, act_ton_q, act_ton_d;
  logic [CNT_W-1:0]  act_toff_q, act_toff_d, act_count_q, act_count_d;
  logic [CNT_W-1:0]  pend_phase_q, pend_phase_d, pend_ton_q, pend_ton_d;
  logic [CNT_W-1:0]  pend_toff_q, pend_toff_d, pend_count_q, pend_count_d;
  logic              pend_q, pend_d, loaded_q, loaded_d, stop_lat_q, stop_lat_d;
  logic              wave_q, wave_d, busy_q, busy_d;
  logic              period_done_q, period_done_d, done_q, done_d, err_q, err_d;

  logic              cfg_fire, cfg_ok, cnt_zero, low_last, count_hit;
  logic [CNT_W-1:0]  per_inc;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_ton != '0) && (cfg_toff != '0);
  assign cnt_zero  = (cnt_q == '0);
  assign low_last  = (state_q == S_LOW) && cnt_zero;
  // Period counter saturates rather than wrapping back to a value that could match count.
  assign per_inc   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + ONE;
  assign count_hit = (act_count_q != '0) && (per_inc == act_count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && loaded_q) begin
          if (act_phase_q != '0) begin
            state_d = S_PHASE;
            cnt_d   = act_phase_q - ONE;
          end else begin
            state_d = S_HIGH;
            cnt_d   = act_ton_q - ONE;
          end
        end
      end
      S_PHASE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_zero) begin
          state_d = S_HIGH;
          cnt_d   = act_ton_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_HIGH: begin
        if (cnt_zero) begin
          state_d = S_LOW;
          cnt_d   = act_toff_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_LOW: begin
        if (cnt_zero) begin
          if (stop_lat_q || count_hit) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HIGH;
            cnt_d   = (pend_q ? pend_ton_q : act_ton_q) - ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    per_cnt_d    = per_cnt_q;
    stop_lat_d   = stop_lat_q;
    act_phase_d  = act_phase_q;
    act_ton_d    = act_ton_q;
    act_toff_d   = act_toff_q;
    act_count_d  = act_count_q;
    pend_phase_d = pend_phase_q;
    pend_ton_d   = pend_ton_q;
    pend_toff_d  = pend_toff_q;
    pend_count_d = pend_count_q;
    pend_d       = pend_q;
    loaded_d     = loaded_q;

    if (state_q == S_IDLE && state_d != S_IDLE) per_cnt_d = '0;
    else if (low_last)                          per_cnt_d = per_inc;

    if ((state_q == S_HIGH || state_q == S_LOW) && stop) stop_lat_d = 1'b1;
    if (state_d == S_IDLE)                                stop_lat_d = 1'b0;

    // Boundary promotion keeps the running phase; landing in IDLE takes the whole set.
    if (pend_q && low_last && state_d == S_HIGH) begin
      act_ton_d   = pend_ton_q;
      act_toff_d  = pend_toff_q;
      act_count_d = pend_count_q;
      pend_d      = 1'b0;
    end else if (pend_q && state_d == S_IDLE) begin
      act_phase_d = pend_phase_q;
      act_ton_d   = pend_ton_q;
      act_toff_d  = pend_toff_q;
      act_count_d = pend_count_q;
      pend_d      = 1'b0;
    end

    if (cfg_fire && cfg_ok) begin
      if (state_q == S_IDLE) begin
        act_phase_d = cfg_phase;
        act_ton_d   = cfg_ton;
        act_toff_d  = cfg_toff;
        act_count_d = cfg_count;
        loaded_d    = 1'b1;
      end else begin
        pend_phase_d = cfg_phase;
        pend_ton_d   = cfg_ton;
        pend_toff_d  = cfg_toff;
        pend_count_d = cfg_count;
        pend_d       = 1'b1;
      end
    end
  end

  always_comb begin
    cfg_ready     = (state_q == S_IDLE) ? 1'b1 : !pend_q;
    wave_d        = (state_q == S_HIGH);
    busy_d        = (state_q != S_IDLE);
    period_done_d = low_last;
    done_d        = (state_q == S_IDLE) && busy_q;
    err_d         = (cfg_fire && !cfg_ok) ||
                    ((state_q == S_IDLE) && start && !stop && !loaded_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      per_cnt_q     <= '0;
      stop_lat_q    <= 1'b0;
      act_phase_q   <= '0;
      act_ton_q     <= '0;
      act_toff_q    <= '0;
      act_count_q   <= '0;
      pend_phase_q  <= '0;
      pend_ton_q    <= '0;
      pend_toff_q   <= '0;
      pend_count_q  <= '0;
      pend_q        <= 1'b0;
      loaded_q      <= 1'b0;
      wave_q        <= 1'b0;
      busy_q        <= 1'b0;
      period_done_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      per_cnt_q     <= per_cnt_d;
      stop_lat_q    <= stop_lat_d;
      act_phase_q   <= act_phase_d;
      act_ton_q     <= act_ton_d;
      act_toff_q    <= act_toff_d;
      act_count_q   <= act_count_d;
      pend_phase_q  <= pend_phase_d;
      pend_ton_q    <= pend_ton_d;
      pend_toff_q   <= pend_toff_d;
      pend_count_q  <= pend_count_d;
      pend_q        <= pend_d;
      loaded_q      <= loaded_d;
      wave_q        <= wave_d;
      busy_q        <= busy_d;
      period_done_q <= period_done_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign wave_out    = wave_q;
  assign busy        = busy_q;
  assign period_done = period_done_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Self-checking bench for clkgen_ctrl: randomized waveform configurations are
// compared cycle by cycle against an arithmetic model of the expected waveform.
module tb_clkgen_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_phase, cfg_ton, cfg_toff, cfg_count;
  logic       start, stop;
  logic       wave_out, busy, period_done, done, err;

  int checks = 0;
  int errors = 0;

  // Model configuration of the run currently being checked
  int ph_m, tn_m, tf_m, n_m;

  clkgen_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_phase(cfg_phase), .cfg_ton(cfg_ton), .cfg_toff(cfg_toff), .cfg_count(cfg_count),
    .start(start), .stop(stop),
    .wave_out(wave_out), .busy(busy), .period_done(period_done), .done(done), .err(err)
  );

  // Free-running reference clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that a stuck design still ends the run
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one configuration for a single cycle
  task automatic load_cfg(input int ph, input int tn, input int tf, input int n);
    cfg_valid = 1'b1;
    cfg_phase = 8'(ph); cfg_ton = 8'(tn); cfg_toff = 8'(tf); cfg_count = 8'(n);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Expected outputs k samples after the start edge, from phase/ton/toff/count arithmetic
  function automatic bit m_wave(int k);
    int t = k - 1 - ph_m;
    int p = tn_m + tf_m;
    if (t < 0) return 1'b0;
    if (n_m != 0 && t >= n_m * p) return 1'b0;
    return (t % p) < tn_m;
  endfunction

  function automatic bit m_pd(int k);
    int t = k - 1 - ph_m;
    int p = tn_m + tf_m;
    if (t < 0) return 1'b0;
    if (n_m != 0 && t >= n_m * p) return 1'b0;
    return (t % p) == p - 1;
  endfunction

  function automatic bit m_busy(int k);
    return k >= 1 && (n_m == 0 || k < n_m * (tn_m + tf_m) + ph_m + 1);
  endfunction

  function automatic bit m_done(int k);
    return n_m != 0 && k == n_m * (tn_m + tf_m) + ph_m + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_phase = '0; cfg_ton = '0; cfg_toff = '0; cfg_count = '0;
    repeat (3) tick();
    checks++; if (wave_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_wave got %0b exp 0", wave_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0 || period_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pulses got %0b%0b%0b exp 000", done, period_done, err);
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b exp 1", cfg_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start_unloaded(input string name);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL %s err_pulse got %0b exp 1", name, err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy got %0b exp 0", name, busy); end
    tick();
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL %s after err/busy got %0b/%0b exp 0/0", name, err, busy);
    end
  endtask

  // Full waveform run; an endless run is closed with stop and a bounded wait for done
  task automatic test_waveform(input string name, input int ph, input int tn, input int tf,
                               input int n, input int cycles);
    int last;
    bit got;
    ph_m = ph; tn_m = tn; tf_m = tf; n_m = n;
    load_cfg(ph, tn, tf, n);
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy_k0 got %0b exp 0", name, busy); end
    last = (n != 0) ? n * (tn + tf) + ph + 2 : cycles;
    for (int k = 1; k <= last; k++) begin
      tick();
      checks++; if (wave_out !== m_wave(k)) begin errors++; $display("[TB] FAIL %s wave k=%0d got %0b exp %0b", name, k, wave_out, m_wave(k)); end
      checks++; if (period_done !== m_pd(k)) begin errors++; $display("[TB] FAIL %s period_done k=%0d got %0b exp %0b", name, k, period_done, m_pd(k)); end
      checks++; if (busy !== m_busy(k)) begin errors++; $display("[TB] FAIL %s busy k=%0d got %0b exp %0b", name, k, busy, m_busy(k)); end
      checks++; if (done !== m_done(k)) begin errors++; $display("[TB] FAIL %s done k=%0d got %0b exp %0b", name, k, done, m_done(k)); end
    end
    if (n == 0) begin
      stop = 1'b1; tick(); stop = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 2 * (tn + tf) + ph + 10 && !got; i++) begin
        tick();
        if (done === 1'b1) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("[TB] FAIL %s stop_done got timeout exp pulse", name); end
      tick();
    end
    checks++; if (busy !== 1'b0 || wave_out !== 1'b0) begin
      errors++; $display("[TB] FAIL %s idle_after got busy=%0b wave=%0b exp 0/0", name, busy, wave_out);
    end
  endtask

  // Stop during the second HIGH cycle: the running period still completes
  task automatic test_graceful_stop();
    ph_m = 0; tn_m = 4; tf_m = 4; n_m = 1;
    load_cfg(0, 4, 4, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    stop = 1'b1;
    for (int k = 2; k <= 11; k++) begin
      tick();
      stop = 1'b0;
      checks++; if (wave_out !== m_wave(k)) begin errors++; $display("[TB] FAIL gstop wave k=%0d got %0b exp %0b", k, wave_out, m_wave(k)); end
      checks++; if (done !== m_done(k) || busy !== m_busy(k)) begin
        errors++; $display("[TB] FAIL gstop done/busy k=%0d got %0b/%0b exp %0b/%0b", k, done, busy, m_done(k), m_busy(k));
      end
    end
  endtask

  // New settings offered mid-period take over at the next period boundary
  task automatic test_reconfig();
    bit ew, ep, got;
    int t;
    load_cfg(0, 3, 5, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    cfg_valid = 1'b1; cfg_phase = 8'd7; cfg_ton = 8'd6; cfg_toff = 8'd2; cfg_count = 8'd0;
    for (int k = 3; k <= 40; k++) begin
      tick();
      if (k == 3) begin
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reconfig ready_pend got %0b exp 0", cfg_ready); end
        cfg_phase = 8'd0; cfg_ton = 8'd1; cfg_toff = 8'd1;
      end
      if (k == 5) cfg_valid = 1'b0;
      if (k == 10) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reconfig ready_free got %0b exp 1", cfg_ready); end
      end
      t  = k - 1;
      ew = (t < 8) ? ((t % 8) < 3) : (((t - 8) % 8) < 6);
      ep = (t % 8) == 7;
      checks++; if (wave_out !== ew) begin errors++; $display("[TB] FAIL reconfig wave k=%0d got %0b exp %0b", k, wave_out, ew); end
      checks++; if (period_done !== ep) begin errors++; $display("[TB] FAIL reconfig period_done k=%0d got %0b exp %0b", k, period_done, ep); end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (done === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL reconfig stop_done got timeout exp pulse"); end
    tick();
  endtask

  // Rejected configuration, start+stop together, then a run on the retained settings
  task automatic test_errors();
    load_cfg(2, 1, 1, 2);
    cfg_valid = 1'b1; cfg_phase = 8'd0; cfg_ton = 8'd5; cfg_toff = 8'd0; cfg_count = 8'd1;
    tick(); cfg_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL errors cfg_reject got %0b exp 1", err); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL errors err_clear got %0b exp 0", err); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin
        errors++; $display("[TB] FAIL errors start_stop got busy=%0b err=%0b exp 0/0", busy, err);
      end
    end
    ph_m = 2; tn_m = 1; tf_m = 1; n_m = 2;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (wave_out !== m_wave(k) || done !== m_done(k)) begin
        errors++; $display("[TB] FAIL errors retained k=%0d got %0b/%0b exp %0b/%0b", k, wave_out, done, m_wave(k), m_done(k));
      end
    end
  endtask

  // Asynchronous reset in the middle of a HIGH phase
  task automatic test_reset_midrun();
    load_cfg(0, 5, 5, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    checks++; if (wave_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid pre_wave got %0b exp 1", wave_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wave_out !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid async got wave=%0b busy=%0b exp 0/0", wave_out, busy);
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid ready got %0b exp 1", cfg_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_start_unloaded("rst_mid_unloaded");
  endtask

  // Randomized finite and endless runs, plus the clk/2 corner
  task automatic test_random();
    test_waveform("min_toggle", 0, 1, 1, 5, 0);
    for (int i = 0; i < 8; i++)
      test_waveform("rand_finite", $urandom_range(0, 6), $urandom_range(1, 5),
                    $urandom_range(1, 5), $urandom_range(1, 4), 0);
    test_waveform("rand_endless", $urandom_range(0, 6), $urandom_range(1, 5),
                  $urandom_range(1, 5), 0, 37);
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_start_unloaded("unloaded");
    test_waveform("basic", 8, 3, 10, 0, 60);
    test_waveform("finite", 0, 2, 2, 3, 0);
    test_graceful_stop();
    test_reconfig();
    test_errors();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkgen_ctrl.md
# clkgen_ctrl

Synthesizable controller that sequences a programmable waveform on `wave_out` from the reference clock `clk`. Each waveform is defined by a phase delay, an on-time and an off-time, all counted in `clk` cycles. It replaces free-running, delay-based clock tasks in the sequential-logic designs with a configurable, start/stop-controlled generator. Configuration is loaded through a valid/ready handshake, double-buffered, and applied only on period boundaries, so the output never glitches.

## Interface
- `CNT_W`, default 8, width of the phase, on-time, off-time and period-count fields.
- `clk`  in  1  reference clock; every flop uses its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted.
- `cfg_phase`  in  CNT_W  cycles of low before the first high; applies only at start.
- `cfg_ton`  in  CNT_W  high cycles per period; must be nonzero.
- `cfg_toff`  in  CNT_W  low cycles per period; must be nonzero.
- `cfg_count`  in  CNT_W  periods to generate; 0 means run forever.
- `start`  in  1  begin generation; single-cycle pulse.
- `stop`  in  1  request a graceful stop; single-cycle pulse.
- `wave_out`  out  1  generated waveform, registered.
- `busy`  out  1  high in every non-IDLE state.
- `period_done`  out  1  one-cycle pulse on the last cycle of each LOW phase.
- `done`  out  1  one-cycle pulse when generation ends.
- `err`  out  1  one-cycle pulse on a rejected configuration or an invalid start.

## Operation
- **Registers.** The active set is {phase, ton, toff, count}. The pending set holds the same fields plus a `pend` flag. A `loaded` flag records whether the active set has ever been written.
- **Handshake.** A configuration transfers when `cfg_valid && cfg_ready`.
  - `cfg_ready` = 1 in IDLE.
  - `cfg_ready` = !`pend` while running.
- **Configuration rejection.** If a transfer carries ton = 0 or toff = 0, the transfer still completes but is rejected: `err` pulses for one cycle and no register changes.
- **Configuration loading.**
  - In IDLE, a valid configuration writes the active set and sets `loaded`.
  - While running, a valid configuration writes the pending set and sets `pend`.
- **FSM states.** IDLE, PHASE, HIGH, LOW. One down-counter is loaded with duration-1 on entry to each timed state.
- **IDLE.**
  - `start && !stop && loaded` goes to PHASE if phase > 0, otherwise to HIGH. The period counter clears on this transition.
  - `start` with `!loaded` stays in IDLE and pulses `err`.
  - `start` and `stop` in the same cycle: nothing happens (stop wins).
  - `stop` alone is ignored.
- **PHASE.** Lasts phase cycles with `wave_out` = 0, then goes to HIGH. A `stop` in PHASE goes to IDLE on the next edge and pulses `done`.
- **HIGH.** Lasts ton cycles with `wave_out` = 1, then goes to LOW.
- **LOW.** Lasts toff cycles with `wave_out` = 0. On its last cycle, `period_done` pulses and the period counter increments (wrap-free; width CNT_W). Then:
  - If the stop request is latched, or count ≠ 0 and the period counter reaches count: go to IDLE and pulse `done`.
  - Otherwise go to HIGH. If `pend` is set, the pending ton, toff and count are copied to the active set on this same edge and `pend` clears. The pending phase is ignored. The period counter is not reset.
- **Stop while running.** A `stop` in HIGH or LOW sets a stop latch. The current period always completes in full. `start` while running is ignored with no `err`.
- **Exit from running.** Any exit to IDLE forces `wave_out` to 0 and clears the stop latch. Pending configuration is retained and is promoted to the active set on entry to IDLE.
- **Reset.** Reset is asynchronous and may arrive mid-operation. It immediately forces:
  - state IDLE;
  - `wave_out`, `busy`, `done`, `period_done`, `err` = 0;
  - `cfg_ready` = 1;
  - all configuration registers, `loaded`, `pend`, counters and the stop latch = 0.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs except `cfg_ready` to `pend`/state.
- `start` sampled at edge E0:
  - `busy` rises at E0+1.
  - `wave_out` rises at E0+phase+1.
  - `wave_out` stays high exactly ton cycles, then low exactly toff cycles.
  - The period is ton+toff cycles, with no dead cycles between periods.
- With count = N, `done` and the fall of `busy` occur on the same edge, exactly N×(ton+toff)+phase+1 cycles after E0.
- A configuration accepted on any cycle of period k takes effect from period k+1 if it was accepted before the last LOW cycle. If accepted on the last LOW cycle, it takes effect from period k+2.
- Minimum settings, ton = toff = 1, produce a toggle on every cycle: `wave_out` runs at clk/2.

## Test plan
- **Basic waveform.** cfg {phase 8, ton 3, toff 10, count 0}, start at E0 → `wave_out` high during edges E0+9..E0+11, then every 13 cycles; `period_done` every 13 cycles.
- **Finite run.** cfg {phase 0, ton 2, toff 2, count 3}, start → exactly 3 high pulses; `done` at E0+13; `busy` = 0 afterwards; `wave_out` = 0.
- **Graceful stop.** Running {0, 4, 4, 0}; `stop` on the 2nd HIGH cycle → that period completes (LOW for 4 cycles), then `done` pulses and the FSM is in IDLE.
- **Reconfiguration.** Running {0, 3, 5, 0}; send {x, 6, 2, 0} mid-period → the current period stays 3/5, the next is 6/2. A second configuration while `pend` = 1 sees `cfg_ready` = 0.
- **Errors.** Configuration with toff = 0 → `err` pulse, no state change. `start` after reset with no configuration → `err` pulse, IDLE. `start`+`stop` in the same cycle → nothing happens.
- **Reset mid-run.** Deassert `rst_n` during HIGH → `wave_out` = 0 and `busy` = 0 immediately. After release, `start` gives `err` (`loaded` was cleared).
